operand_debounce: RTL

OPERAND_DEBOUNCE -- requirements
Module: operand_debounce

---
 rtl/operand_debounce.sv | 112 +++++++++++
 1 files changed

// File: rtl/operand_debounce.sv
// Two-flop synchronizer plus debounce FSM for the 4-bit operand inputs A and B.
// Define OPERAND_DEBOUNCE_EN to enable the debounce FSM; otherwise synchronized inputs pass straight through.
module operand_debounce #(
    parameter int DEBOUNCE_CYCLES = 12000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] raw_a,
    input  logic [3:0] raw_b,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic       upd,
    output logic       busy
);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_param
        $error("operand_debounce: DEBOUNCE_CYCLES out of range 2..65535");
    end

    logic [7:0] sync1;
    logic [7:0] sync2;

    // Both operands share one synchronizer vector: s = {raw_b, raw_a}.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 8'h00;
            sync2 <= 8'h00;
        end else begin
            sync1 <= {raw_b, raw_a};
            sync2 <= sync1;
        end
    end

`ifdef OPERAND_DEBOUNCE_EN

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    localparam logic [15:0] LAST = 16'(DEBOUNCE_CYCLES - 1);

    state_t      state;
    logic [7:0]  cand;
    logic [15:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cand  <= 8'h00;
            cnt   <= 16'h0000;
            a     <= 4'h0;
            b     <= 4'h0;
            upd   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            upd <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= 16'h0000;
                    if (sync2 != {b, a}) begin
                        state <= SETTLE;
                        busy  <= 1'b1;
                        cand  <= sync2;
                    end
                end
                SETTLE: begin
                    if (sync2 != cand) begin
                        cand <= sync2;
                        cnt  <= 16'h0000;
                    end else if (cnt < LAST) begin
                        cnt <= cnt + 16'h0001;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= 16'h0000;
                        // A glitch that settled back to the committed value is dropped silently.
                        if (cand != {b, a}) begin
                            {b, a} <= cand;
                            upd    <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    cnt   <= 16'h0000;
                end
            endcase
        end
    end

`else

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a   <= 4'h0;
            b   <= 4'h0;
            upd <= 1'b0;
        end else begin
            upd <= (sync2 != {b, a});
            if (sync2 != {b, a}) begin
                {b, a} <= sync2;
            end
        end
    end

    assign busy = 1'b0;

`endif

endmodule
